// File: rtl/aes_key_expansion_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expansion_if
// Description : Key-load / round-key read bus between the key schedule and
//               the encrypt core.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expansion_if #(
    parameter int KEY_WIDTH  = 256,
    parameter int DATA_WIDTH = 128
);
    logic                  start;
    logic [KEY_WIDTH-1:0]  key_in;
    logic [3:0]            round_key_addr;
    logic [DATA_WIDTH-1:0] round_key;
    logic                  round_key_rdy;
    logic                  busy;

    modport master (
        output start, key_in, round_key_addr,
        input  round_key, round_key_rdy, busy
    );

    modport slave (
        input  start, key_in, round_key_addr,
        output round_key, round_key_rdy, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expansion
// Description : Iterative AES-256 key schedule, one round key per clock, with
//               a combinational round-key read port. Optional macro
//               AES_KEY_EXP_RESTART_EN lets start abort a running expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expansion #(
    parameter int KEY_WIDTH  = 256,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_RK     = 15
) (
    input  logic                 Clk,
    input  logic                 Rst,
    aes_key_expansion_if.slave   bus
);

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_RK - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rk_q [NUM_RK];
    logic [DATA_WIDTH-1:0] rk_d [NUM_RK];
    logic [3:0]            gen_idx_q, gen_idx_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;

    logic                  w_load;
    logic [3:0]            w_p1_idx, w_p2_idx;
    logic [31:0]           w_p1w3, w_t, w_n0, w_n1, w_n2, w_n3;
    logic [DATA_WIDTH-1:0] w_p2;
    logic [7:0]            w_rcon;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254 in GF(2^8)) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] inv;
        acc = x;
        for (int i = 0; i < 6; i++) acc = gf_mul(gf_mul(acc, acc), x);
        inv = gf_mul(acc, acc);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Clamped so the read indices stay in range outside EXPAND
    assign w_p1_idx = (gen_idx_q >= 4'd2) ? gen_idx_q - 4'd1 : 4'd0;
    assign w_p2_idx = (gen_idx_q >= 4'd2) ? gen_idx_q - 4'd2 : 4'd0;
    assign w_p1w3   = rk_q[w_p1_idx][31:0];
    assign w_p2     = rk_q[w_p2_idx];
    assign w_rcon   = 8'h01 << (gen_idx_q[3:1] - 3'd1);

    assign w_t  = gen_idx_q[0] ? sub_word(w_p1w3)
                               : sub_word({w_p1w3[23:0], w_p1w3[31:24]}) ^ {w_rcon, 24'h0};
    assign w_n0 = w_p2[127:96] ^ w_t;
    assign w_n1 = w_p2[95:64]  ^ w_n0;
    assign w_n2 = w_p2[63:32]  ^ w_n1;
    assign w_n3 = w_p2[31:0]   ^ w_n2;

`ifdef AES_KEY_EXP_RESTART_EN
    assign w_load = bus.start;
`else
    assign w_load = bus.start && (state_q != ST_EXPAND);
`endif

    always_comb begin
        state_d   = state_q;
        rk_d      = rk_q;
        gen_idx_d = gen_idx_q;
        rdy_d     = rdy_q;
        busy_d    = busy_q;
        if (w_load) begin
            rk_d[0]   = bus.key_in[KEY_WIDTH-1 -: DATA_WIDTH];
            rk_d[1]   = bus.key_in[DATA_WIDTH-1:0];
            gen_idx_d = 4'd2;
            rdy_d     = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_EXPAND;
        end else if (state_q == ST_EXPAND) begin
            rk_d[gen_idx_q] = {w_n0, w_n1, w_n2, w_n3};
            gen_idx_d       = gen_idx_q + 4'd1;
            if (gen_idx_q == c_LAST_IDX) begin
                state_d = ST_READY;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            gen_idx_q <= 4'd0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            gen_idx_q <= gen_idx_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            rk_q      <= rk_d;
        end
    end

    assign bus.round_key     = (bus.round_key_addr <= c_LAST_IDX) ? rk_q[bus.round_key_addr] : '0;
    assign bus.round_key_rdy = rdy_q;
    assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expansion
// Description : Scoreboard bench for aes_key_expansion against a word-level
//               key schedule model and FIPS-197 known answers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expansion;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [1919:0] exp_q [$];
    int            exp_cyc_q [$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    aes_key_expansion_if bus ();

    aes_key_expansion dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[127 - 8*x[3:0] -: 8];
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // FIPS-197 word recurrence; round key k lives at bits [k*128 +: 128]
    function automatic logic [1919:0] model_expand(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] r;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)      t = sw({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) t = sw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) r[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1919:0] rk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] st;
        st = pt ^ rk[127:0];
        for (int r = 1; r < 15; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sb(st[127 - 8*k -: 8]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 14) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
                end
            end
            for (int k = 0; k < 16; k++) st[127 - 8*k -: 8] = s[k];
            st = st ^ rk[r*128 +: 128];
        end
        return st;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [255:0] k);
        bus.key_in = k;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int i = 0; i < 8; i++) bus.key_in[32*i +: 32] = $urandom();
    endtask

    task automatic push_exp(input logic [255:0] k, input int rdy_cyc);
        exp_q.push_back(model_expand(k));
        exp_cyc_q.push_back(rdy_cyc);
    endtask

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (!bus.round_key_rdy && n < 40) begin
            tick();
            n++;
        end
        if (!bus.round_key_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: round_key_rdy got 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic sweep(output logic [1919:0] dk);
        dk = '0;
        for (int a = 0; a < 16; a++) begin
            bus.round_key_addr = 4'(a);
            @(negedge Clk);
            if (a < 15) dk[a*128 +: 128] = bus.round_key;
            tick();
        end
    endtask

    // Monitor: each rdy rise pops the next expected key set and its cycle,
    // then every read while rdy is high is compared against that set.
    initial begin
        logic [1919:0] cur;
        logic          have;
        logic          rdy_prev;
        int            ec;
        have     = 1'b0;
        rdy_prev = 1'b0;
        cur      = '0;
        forever begin
            @(negedge Clk);
            if (bus.round_key_rdy && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    have = 1'b0;
                    $display("FAIL unexpected_rdy: got rdy at cycle %0d expected none", cyc);
                end else begin
                    cur  = exp_q.pop_front();
                    ec   = exp_cyc_q.pop_front();
                    have = 1'b1;
                    chk("rdy_latency", 128'(cyc), 128'(ec));
                end
            end
            if (bus.round_key_rdy && have)
                chk($sformatf("rk_read[%0d]", bus.round_key_addr), bus.round_key,
                    (bus.round_key_addr == 4'd15) ? 128'h0 : cur[int'(bus.round_key_addr)*128 +: 128]);
            rdy_prev = bus.round_key_rdy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1919:0] dk;
        logic [255:0]  rk;
        int            s1;
        bus.start          = 1'b0;
        bus.key_in         = '0;
        bus.round_key_addr = 4'd0;
        Rst = 1'b1;
        repeat (3) tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("reset_rdy",  128'(bus.round_key_rdy), 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_rk0",  bus.round_key, 128'h0);
        tick();

        // FIPS-197 C.3 key
        do_start(KEY_C3);
        push_exp(KEY_C3, cyc + 13);
        @(negedge Clk);
        chk("busy_expand", 128'(bus.busy), 128'd1);
        wait_rdy("c3");
        chk("busy_ready", 128'(bus.busy), 128'd0);
        sweep(dk);
        chk("c3_rk0",  dk[0*128 +: 128],  KEY_C3[255:128]);
        chk("c3_rk1",  dk[1*128 +: 128],  KEY_C3[127:0]);
        chk("c3_rk2",  dk[2*128 +: 128],  128'ha573c29fa176c498a97fce93a572c09c);
        chk("c3_rk14", dk[14*128 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        chk("c3_encrypt", aes_enc(128'h00112233445566778899aabbccddeeff, dk),
            128'h8ea2b7ca516745bfeafc49904b496089);

        // Read of address 15 in READY, then restart with A.3 key
        bus.round_key_addr = 4'd15;
        @(negedge Clk);
        chk("addr15_zero", bus.round_key, 128'h0);
        do_start(KEY_A3);
        push_exp(KEY_A3, cyc + 13);
        @(negedge Clk);
        chk("rdy_drop", 128'(bus.round_key_rdy), 128'd0);
        wait_rdy("a3");
        sweep(dk);
        chk("a3_rk14", dk[14*128 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

        // Reset at generate edge 6
        do_start(KEY_C3);
        repeat (5) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_rdy",  128'(bus.round_key_rdy), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        for (int a = 0; a < 16; a++) begin
            bus.round_key_addr = 4'(a);
            #1;
            chk($sformatf("midrst_rk[%0d]", a), bus.round_key, 128'h0);
        end
        tick();
        do_start(KEY_C3);
        push_exp(KEY_C3, cyc + 13);
        wait_rdy("c3_after_rst");
        sweep(dk);
        chk("c3_after_rst_rk14", dk[14*128 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // start during the 5th EXPAND edge with a different key
        do_start(KEY_C3);
        s1 = cyc;
        repeat (4) tick();
        do_start(KEY_A3);
`ifdef AES_KEY_EXP_RESTART_EN
        push_exp(KEY_A3, cyc + 13);
`else
        push_exp(KEY_C3, s1 + 13);
`endif
        wait_rdy("restart");
        sweep(dk);

        // Random keys
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom();
            do_start(rk);
            push_exp(rk, cyc + 13);
            wait_rdy("random");
            sweep(dk);
        end

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-256 key schedule that sits directly upstream of the AES encrypt datapath.
- Accepts a 256-bit cipher key and generates the 15 round keys (rk0..rk14), one per clock.
- Stores the round keys in an internal register file and serves them on a combinational read port addressed by the encrypt core's round counter.
- Asserts round_key_rdy once all keys are valid; the encrypt core ANDs this with its enable.

Parameters:
- KEY_WIDTH, 256, cipher key width; only 256 is supported.
- DATA_WIDTH, 128, round key width.
- NUM_RK, 15, number of stored round keys.

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to load key_in and expand it.
- key_in  input  256  cipher key; [255:128] = rk0, [127:0] = rk1.
- round_key_addr  input  4  round key index from the encrypt core.
- round_key  output  128  rk[round_key_addr], combinational read.
- round_key_rdy  output  1  high when rk0..rk14 are all valid.
- busy  output  1  high while expansion is in progress.

Behaviour:
- Reset: Rst high at a rising edge sets state=IDLE, round_key_rdy=0, busy=0, gen_idx=0, and clears all 15 key registers to 0. round_key therefore reads 0. Reset has priority over start, including mid-expansion.
- FSM states and transitions:
  - IDLE: start -> EXPAND.
  - EXPAND: after rk14 is written -> READY.
  - READY: start -> EXPAND.
  - In IDLE and READY, start=0 holds the current state.
- Start edge (start=1 in IDLE or READY):
  - rk0 <= key_in[255:128], rk1 <= key_in[127:0].
  - gen_idx <= 2, round_key_rdy <= 0, busy <= 1.
- EXPAND, each edge computes rk[gen_idx] from p2 = rk[gen_idx-2] and p1 = rk[gen_idx-1]:
  - Words are taken MSB first: p1 = {p1w0, p1w1, p1w2, p1w3}; the same split applies to p2.
  - Even gen_idx: t = SubWord(RotWord(p1w3)) ^ {Rcon[gen_idx/2], 24'h0}. RotWord is {b1,b2,b3,b0}, where b0 is the MSB byte.
  - Odd gen_idx: t = SubWord(p1w3).
  - n0 = p2w0^t, n1 = p2w1^n0, n2 = p2w2^n1, n3 = p2w3^n2; rk[gen_idx] <= {n0,n1,n2,n3}.
  - Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40 (hex).
  - SubWord is four byte S-boxes using the same mapping as the encrypt SubBytes stage.
  - gen_idx increments by 1 each edge.
  - The edge that writes rk14 also sets state=READY, round_key_rdy=1, busy=0.
- Latency: 14 rising edges from the edge that samples start until round_key_rdy reads 1. That is 1 load edge plus 13 generate edges.
- start while in EXPAND is ignored (see Optional Feature).
- start while in READY drops round_key_rdy on the next edge. Stored keys are overwritten progressively.
- Read port:
  - round_key = rk[round_key_addr] whenever round_key_addr <= 14.
  - round_key_addr = 15 returns 128'h0.
  - Reads are valid in any state. Consumers gate on round_key_rdy.
- key_in is sampled only on the start edge. It may change freely afterwards.

Optional Feature:
- Macro: AES_KEY_EXP_RESTART_EN.
- Defined: start during EXPAND aborts the current expansion on that edge. It reloads rk0/rk1 from key_in, sets gen_idx <= 2 and keeps busy=1, round_key_rdy=0. Full 14-edge latency restarts from that edge.
- Undefined: start during EXPAND has no effect; the expansion completes with the original key.

Test Plan:
- FIPS-197 C.3 key 000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, one-cycle start:
  - round_key_rdy rises exactly 14 edges later.
  - addr=2 -> a573c29fa176c498a97fce93a572c09c.
  - addr=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
  - addr=0/1 -> key halves.
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> addr=14 -> fe4890d1e6188d0b046df344706c631e.
- Rst asserted at generate edge 6, then released -> round_key_rdy=0, busy=0, and all addresses read 0. A fresh start then yields the correct C.3 keys.
- start pulsed at the 5th EXPAND cycle with a different key_in:
  - Macro undefined: results equal the C.3 keys.
  - Macro defined: results equal the A.3 keys, rdy 14 edges after the second start.
- In READY, addr=15 -> 0. A second start drops rdy on the next edge, and new keys are valid 14 edges after that start.
- Connected to the encrypt core with the C.3 key and plaintext 00112233445566778899aabbccddeeff -> ciphertext 8ea2b7ca516745bfeafc49904b496089.
